mux4_rr_arb: RTL and testbench
==============================

MUX4_RR_ARB -- requirements
Module: mux4_rr_arb

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum consecutive grant cycles per owner; 0 disables the timeout.
REQ-002 Port: clk  input  1  the single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  per-requester request, bit i = requester i.
REQ-005 Port: rel  input  4  per-requester release; sampled only for the current owner.
REQ-006 Port: gnt  output  4  one-hot grant, all-zero when idle.
REQ-007 Port: s0, s1, s2  output  1 each  one-hot mux selects (at most one high); all low selects d3.
REQ-008 Port: sel_vld  output  1  high when the shared 4:1 mux output belongs to a granted owner.
REQ-009 Port: owner  output  2  encoded index of the granted requester; holds its last value when idle.
REQ-010 Port: timeout  output  1  single-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-012 In IDLE with any req bit high, the block SHALL pick the first set bit searching from ptr+1 upward modulo 4 (ptr = last owner), enter BUSY and assert gnt on the next cycle (latency 1).
REQ-013 In IDLE with req==0, gnt SHALL stay 0 and ptr SHALL be unchanged.
REQ-014 s0=gnt[0], s1=gnt[1], s2=gnt[2] and sel_vld=|gnt, all registered; gnt[3] drives all selects low.
REQ-015 In BUSY, gnt SHALL hold while req[owner]=1, rel[owner]=0 and the hold count has not expired.
REQ-016 Release SHALL occur on rel[owner]=1 or req[owner]=0; gnt drops to 0 on the next edge and the FSM returns to IDLE.
REQ-017 Hold counter: 1 on the first grant cycle, incremented each BUSY cycle; when MAX_HOLD>0 and the count equals MAX_HOLD with no release, the grant SHALL be revoked and timeout pulsed for the cycle in which gnt drops.
REQ-018 Simultaneous rel[owner] and expiry SHALL be treated as a normal release with no timeout pulse.
REQ-019 rel bits of non-owners SHALL be ignored; req changes of non-owners SHALL not affect BUSY.
REQ-020 Every release SHALL be followed by at least one IDLE cycle with gnt=0 (select turnaround), so two owners never see back-to-back selects.
REQ-021 On every release ptr SHALL be loaded with owner.
REQ-022 Counter width SHALL be $clog2(MAX_HOLD+1), minimum 1; no wrap is possible in BUSY.

Reset
REQ-023 On rst_n low, asynchronously: state=IDLE, gnt=0, s0/s1/s2=0, sel_vld=0, owner=0, timeout=0, counter=0, ptr=3 (requester 0 wins first).
REQ-024 Reset asserted mid-grant SHALL drop gnt and selects immediately, without a timeout pulse.
REQ-025 The first arbitration SHALL occur on the first rising edge after rst_n deasserts.

Structure
REQ-026 Package mux4_arb_pkg SHALL hold the state enum, N_REQ=4 and OWNER_W=2.
REQ-027 Round-robin selection SHALL live in one combinational sub-module rr_pick (inputs req, ptr; outputs one-hot and index).
REQ-028 A non-synthesized check SHALL flag any cycle with more than one of s0/s1/s2 high, or with gnt not one-hot-or-zero.

Verification
REQ-029 Reset release with req=4'b1111: gnt=0001 one cycle later; owner=0; s0=1.
REQ-030 Owner 0 pulses rel, req stays 1111: gnt=0000 for one cycle, then 0010; repeat rel gives 0100, then 1000 (s0=s1=s2=0, sel_vld=1), then wraps to 0001.
REQ-031 MAX_HOLD=4, req=0100 held, no rel: gnt=0100 for exactly 4 cycles, timeout pulses once, gnt=0 for one cycle, then 0100 is granted again.
REQ-032 rel[owner] asserted in the same cycle the count reaches MAX_HOLD: release without a timeout pulse.
REQ-033 Owner 2 granted, rel=4'b1011 (non-owners only): gnt stays 0100.
REQ-034 rst_n driven low mid-grant, asynchronously to clk: gnt, selects and sel_vld go to 0 immediately; after release, req=0010 yields gnt=0010 one cycle later.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
// Holds the FSM state encoding and the requester/owner widths.
package mux4_arb_pkg;

   localparam int N_REQ   = 4;
   localparam int OWNER_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   function automatic logic onehot0(input logic [N_REQ-1:0] v);
      return (v & (v - N_REQ'(1))) == N_REQ'(0);
   endfunction

endpackage

// File: rtl/mux4_rr_arb_chk.sv
// Simulation-only checker: selects stay one-hot-or-zero and gnt is
// one-hot-or-zero on every clock while out of reset.
module mux4_rr_arb_chk
   import mux4_arb_pkg::*;
(
   input logic             clk,
   input logic             rst_n,
   input logic [N_REQ-1:0] gnt,
   input logic             s0,
   input logic             s1,
   input logic             s2
);

   a_sel_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
      ($countones({s2, s1, s0}) <= 1))
      else $error("select lines not one-hot-or-zero: %b", {s2, s1, s0});

   a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
      onehot0(gnt))
      else $error("gnt not one-hot-or-zero: %b", gnt);

endmodule

// File: rtl/mux4_rr_arb_rr_pick.sv
// Combinational round-robin picker: first set request above ptr, wrapping
// modulo N_REQ, returned both as a one-hot vector and as an index.
module rr_pick
   import mux4_arb_pkg::*;
(
   input  logic [N_REQ-1:0]   req,
   input  logic [OWNER_W-1:0] ptr,
   output logic [N_REQ-1:0]   pick_oh,
   output logic [OWNER_W-1:0] pick_idx,
   output logic               pick_vld
);

   // Scan downward so the nearest candidate after ptr is written last and wins.
   always_comb begin
      logic [OWNER_W-1:0] cand;
      cand     = ptr;
      pick_idx = ptr;
      for (int k = N_REQ; k >= 1; k--) begin
         cand     = ptr + OWNER_W'(k);
         pick_idx = req[cand] ? cand : pick_idx;
      end
      pick_vld = |req;
      pick_oh  = pick_vld ? (N_REQ'(1) << pick_idx) : N_REQ'(0);
   end

endmodule

// File: rtl/mux4_rr_arb.sv
// Four-requester round-robin arbiter driving the selects of a shared 4:1 mux,
// with optional per-owner hold limit (MAX_HOLD=0 disables the limit).
module mux4_rr_arb
   import mux4_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ-1:0]   rel,
   output logic [N_REQ-1:0]   gnt,
   output logic               s0,
   output logic               s1,
   output logic               s2,
   output logic               sel_vld,
   output logic [OWNER_W-1:0] owner,
   output logic               timeout
);

   localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_e               state_q, state_d;
   logic [N_REQ-1:0]     gnt_q, gnt_d;
   logic [OWNER_W-1:0]   owner_q, owner_d;
   logic [OWNER_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 timeout_q, timeout_d;
   logic [2:0]           sel_q, sel_d;
   logic                 sel_vld_q, sel_vld_d;

   logic [N_REQ-1:0]     pick_oh;
   logic [OWNER_W-1:0]   pick_idx;
   logic                 pick_vld;
   logic                 release_s;
   logic                 expired_s;

   rr_pick u_pick (
      .req      (req),
      .ptr      (ptr_q),
      .pick_oh  (pick_oh),
      .pick_idx (pick_idx),
      .pick_vld (pick_vld)
   );

   assign release_s = rel[owner_q] | ~req[owner_q];
   assign expired_s = (MAX_HOLD > 0) && (cnt_q == HOLD_LIM);

   // Next-state logic; a release always parks in IDLE for one cycle so that
   // two owners never see back-to-back selects.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d = BUSY;
               gnt_d   = pick_oh;
               owner_d = pick_idx;
               cnt_d   = CNT_W'(1);
            end else begin
               gnt_d   = N_REQ'(0);
            end
         end
         BUSY: begin
            if (release_s || expired_s) begin
               state_d   = IDLE;
               gnt_d     = N_REQ'(0);
               ptr_d     = owner_q;
               cnt_d     = CNT_W'(0);
               timeout_d = ~release_s;
            end else begin
               cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = N_REQ'(0);
            cnt_d   = CNT_W'(0);
         end
      endcase
      sel_d     = gnt_d[2:0];
      sel_vld_d = |gnt_d;
   end

   // State and output registers; ptr resets to 3 so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= N_REQ'(0);
         owner_q   <= OWNER_W'(0);
         ptr_q     <= OWNER_W'(3);
         cnt_q     <= CNT_W'(0);
         timeout_q <= 1'b0;
         sel_q     <= 3'b000;
         sel_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         sel_q     <= sel_d;
         sel_vld_q <= sel_vld_d;
      end
   end

   assign gnt     = gnt_q;
   assign s0      = sel_q[0];
   assign s1      = sel_q[1];
   assign s2      = sel_q[2];
   assign sel_vld = sel_vld_q;
   assign owner   = owner_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arb.sv
// Scoreboard bench for mux4_rr_arb (MAX_HOLD=4): directed steps push expected
// per-cycle outputs; a negedge monitor pops and compares them.
module tb_mux4_rr_arb;
   import mux4_arb_pkg::*;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req   = 4'b0000;
   logic [3:0] rel   = 4'b0000;
   logic [3:0] gnt;
   logic       s0, s1, s2, sel_vld, timeout;
   logic [1:0] owner;

   typedef struct {
      int         cyc;
      logic [3:0] gnt;
      logic [1:0] owner;
      logic       to;
   } exp_t;

   exp_t sb_q[$];
   exp_t e_m;
   int   cyc_cnt = 0;
   int   checks  = 0;
   int   errors  = 0;

   always #5 clk = ~clk;

   mux4_rr_arb #(.MAX_HOLD(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .rel     (rel),
      .gnt     (gnt),
      .s0      (s0),
      .s1      (s1),
      .s2      (s2),
      .sel_vld (sel_vld),
      .owner   (owner),
      .timeout (timeout)
   );

   mux4_rr_arb_chk u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .gnt   (gnt),
      .s0    (s0),
      .s1    (s1),
      .s2    (s2)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   // Drive one cycle of inputs and record what the outputs must be after the next edge.
   task automatic step(input logic [3:0] r, input logic [3:0] l,
                       input logic [3:0] eg, input logic [1:0] eo, input logic et);
      exp_t e;
      req     = r;
      rel     = l;
      e.cyc   = cyc_cnt + 1;
      e.gnt   = eg;
      e.owner = eo;
      e.to    = et;
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Monitor: compare the registered outputs against the entry due this cycle.
   always @(negedge clk) begin
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc_cnt) begin
         e_m = sb_q.pop_front();
         chk("gnt",     8'(gnt),            8'(e_m.gnt));
         chk("selects", 8'({s2, s1, s0}),   8'(e_m.gnt[2:0]));
         chk("sel_vld", 8'(sel_vld),        8'(|e_m.gnt));
         chk("owner",   8'(owner),          8'(e_m.owner));
         chk("timeout", 8'(timeout),        8'(e_m.to));
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_gnt",     8'(gnt),          8'h00);
      chk("rst_selects", 8'({s2, s1, s0}), 8'h00);
      chk("rst_sel_vld", 8'(sel_vld),      8'h00);
      chk("rst_owner",   8'(owner),        8'h00);
      chk("rst_timeout", 8'(timeout),      8'h00);

      rst_n = 1'b1;
      step(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0);
      // Rotation through all owners with a turnaround cycle after each release.
      step(4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0);
      step(4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0);
      step(4'b1111, 4'b0010, 4'b0000, 2'd1, 1'b0);
      step(4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0);
      step(4'b1111, 4'b0100, 4'b0000, 2'd2, 1'b0);
      step(4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0);
      step(4'b1111, 4'b1000, 4'b0000, 2'd3, 1'b0);
      step(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0);
      step(4'b1110, 4'b0000, 4'b0000, 2'd0, 1'b0);
      step(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
      step(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
      // Hold limit: four grant cycles, timeout with gnt low, then re-grant.
      step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
      step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
      step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
      step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
      step(4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b1);
      step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
      // Non-owner rel/req ignored, then release coinciding with expiry.
      step(4'b0100, 4'b1011, 4'b0100, 2'd2, 1'b0);
      step(4'b1111, 4'b1011, 4'b0100, 2'd2, 1'b0);
      step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
      step(4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0);
      step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);

      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_gnt",     8'(gnt),          8'h00);
      chk("arst_selects", 8'({s2, s1, s0}), 8'h00);
      chk("arst_sel_vld", 8'(sel_vld),      8'h00);
      chk("arst_timeout", 8'(timeout),      8'h00);
      chk("arst_owner",   8'(owner),        8'h00);

      @(negedge clk);
      rst_n = 1'b1;
      step(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
      step(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
      step(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0);

      repeat (2) @(negedge clk);
      chk("sb_drain", 8'(sb_q.size()), 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
